// File: rtl/os_pe_pkg.sv
// os_pe_pkg: saturation bounds, result-buffer states and elaboration check shared by the PE.
`define OS_PE_STATIC_ASSERT(cond, msg) if (!(cond)) begin : g_static_assert $error(msg); end

package os_pe_pkg;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;
  function automatic longint umax(int w);
    return (longint'(1) << w) - 1;
  endfunction
  function automatic longint smax(int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction
  function automatic longint smin(int w);
    return -(longint'(1) << (w - 1));
  endfunction
endpackage

// File: rtl/os_pe_mac.sv
// os_pe_mac: combinational multiply-accumulate with signed/unsigned two-sided saturation.
module os_pe_mac import os_pe_pkg::*; #(
  parameter int DAT_WIDTH = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic [DAT_WIDTH-1:0] i_a,
  input  logic [DAT_WIDTH-1:0] i_b,
  input  logic [ACC_WIDTH-1:0] i_addend,
  input  logic                 i_signed,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_sat
);
  localparam int SW = ACC_WIDTH + 2;
  localparam logic signed [SW-1:0] UMAX = SW'(umax(ACC_WIDTH));
  localparam logic signed [SW-1:0] SMAX = SW'(smax(ACC_WIDTH));
  localparam logic signed [SW-1:0] SMIN = SW'(smin(ACC_WIDTH));
  logic signed [DAT_WIDTH:0] w_a, w_b;
  logic signed [SW-1:0] w_prod, w_add, w_sum;
  logic w_hi, w_lo;
  // one extra bit per operand lets a single signed multiply cover both modes
  assign w_a    = {i_signed & i_a[DAT_WIDTH-1], i_a};
  assign w_b    = {i_signed & i_b[DAT_WIDTH-1], i_b};
  assign w_prod = SW'(w_a) * SW'(w_b);
  assign w_add  = {{2{i_signed & i_addend[ACC_WIDTH-1]}}, i_addend};
  assign w_sum  = w_prod + w_add;
  assign w_hi   = w_sum > (i_signed ? SMAX : UMAX);
  assign w_lo   = i_signed & (w_sum < SMIN);
  assign o_sat  = w_hi | w_lo;
  assign o_sum  = w_hi ? (i_signed ? SMAX[ACC_WIDTH-1:0] : UMAX[ACC_WIDTH-1:0]) :
                  w_lo ? SMIN[ACC_WIDTH-1:0] : w_sum[ACC_WIDTH-1:0];
endmodule

// File: rtl/os_pe_db.sv
// os_pe_db: output-stationary systolic PE with in-band tile framing and a double-buffered result drain.
module os_pe_db import os_pe_pkg::*; #(
  parameter int DAT_WIDTH = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_row_en,
  input  logic [DAT_WIDTH-1:0] din_row,
  input  logic [DAT_WIDTH-1:0] din_col,
  input  logic                 din_first,
  input  logic                 din_last,
  input  logic                 mode_signed,
  output logic                 dout_row_en,
  output logic [DAT_WIDTH-1:0] dout_row,
  output logic [DAT_WIDTH-1:0] dout_col,
  output logic                 dout_first,
  output logic                 dout_last,
  output logic                 mode_signed_out,
  input  logic                 load_en,
  input  logic                 shift_en,
  input  logic [ACC_WIDTH-1:0] shift_dat_in,
  input  logic                 shift_vld_in,
  input  logic                 shift_sat_in,
  output logic [ACC_WIDTH-1:0] shift_dat_out,
  output logic                 shift_vld_out,
  output logic                 shift_sat_out,
  output logic                 res_pending,
  output logic                 err_overrun
);
  `OS_PE_STATIC_ASSERT(ACC_WIDTH >= 2 * DAT_WIDTH, "ACC_WIDTH must be at least 2*DAT_WIDTH")
  buf_state_t r_state, w_next;
  logic [ACC_WIDTH-1:0] r_acc, r_res, w_sum;
  logic r_sat, r_mode, r_res_sat, w_sat, w_sat_tile, w_last;
  os_pe_mac #(.DAT_WIDTH(DAT_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .i_a      (din_row),
    .i_b      (din_col),
    .i_addend (din_first ? '0 : r_acc),
    .i_signed (din_first ? mode_signed : r_mode),
    .o_sum    (w_sum),
    .o_sat    (w_sat)
  );
  assign w_last      = din_row_en & din_last;
  assign w_sat_tile  = w_sat | (~din_first & r_sat);
  assign res_pending = r_state == FULL;
  always_ff @(posedge clk) r_state <= !rst_n ? EMPTY : w_next;
  // a last beat always leaves a result buffered, even when it coincides with a load
  always_comb begin
    w_next = r_state;
    w_next = w_last ? FULL : load_en ? EMPTY : r_state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {dout_row_en, dout_row, dout_col, dout_first, dout_last, mode_signed_out} <= '0;
      {r_acc, r_sat, r_mode, r_res, r_res_sat, err_overrun} <= '0;
      {shift_dat_out, shift_vld_out, shift_sat_out} <= '0;
    end else begin
      {dout_row_en, dout_row, dout_col} <= {din_row_en, din_row, din_col};
      {dout_first, dout_last, mode_signed_out} <= {din_first, din_last, mode_signed};
      if (din_row_en) begin
        r_acc <= w_sum;
        r_sat <= w_sat_tile;
        if (din_first) r_mode <= mode_signed;
      end
      if (w_last) {r_res, r_res_sat} <= {w_sum, w_sat_tile};
      if (w_last && r_state == FULL && !load_en) err_overrun <= 1'b1;
      if (load_en) {shift_dat_out, shift_vld_out, shift_sat_out} <= {r_res, r_state == FULL, r_res_sat};
      else if (shift_en) {shift_dat_out, shift_vld_out, shift_sat_out} <= {shift_dat_in, shift_vld_in, shift_sat_in};
    end
  end
endmodule
